// File: rtl/prog_loader.sv
// prog_loader: parses a length-prefixed byte stream into 32-bit little-endian
// words and writes them into instruction memory from word 0. The CPU is held
// in reset until a complete image has landed.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CKSUM, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  // 17 bits so a MAX_WORDS of 65536 would still compare correctly
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [1:0]  byte_idx;
  logic        xfer;
  logic [15:0] len_full;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer     = byte_valid && byte_ready;
  assign len_full = {byte_data, len_lo};

  // Loader FSM; every output is a register updated alongside the state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      len_lo     <= 8'h00;
      n_words    <= 16'h0000;
      byte_idx   <= 2'd0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= 16'h0000;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      // write strobe lasts exactly the one WRITE cycle
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN_LO;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 16'h0000;
            imem_addr  <= '0;
            byte_idx   <= 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= 8'h00;
`endif
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo <= byte_data;
            state  <= S_LEN_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum   <= csum ^ byte_data;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            n_words <= len_full;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum    <= csum ^ byte_data;
`endif
            if ({1'b0, len_full} > MAX_N) begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else if (len_full == 16'h0000) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state      <= S_CKSUM;
`else
              state      <= S_DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            // bytes arrive LSB first, so byte k lands in lane k
            imem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data;
`endif
            if (byte_idx == 2'd3) begin
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              imem_we    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          imem_addr  <= imem_addr + 1'b1;
          word_count <= word_count + 16'd1;
          if (word_count + 16'd1 < n_words) begin
            state      <= S_DATA;
            byte_ready <= 1'b1;
          end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state      <= S_CKSUM;
            byte_ready <= 1'b1;
`else
            state      <= S_DONE;
            done       <= 1'b1;
            cpu_hold   <= 1'b0;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CKSUM: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (byte_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              // written words stay in memory; the CPU just stays held
              state    <= S_ERR;
              error    <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
